// File: rtl/refill_read_arbiter.sv
// Shares one AR/R refill read port among NUM_MASTERS cache requesters, one transaction at a time.
// Define REFILL_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module refill_read_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_ar_addr,
    input  logic [NUM_MASTERS-1:0]        m_ar_valid,
    output logic [NUM_MASTERS-1:0]        m_ar_ready,
    output logic [DATA_W-1:0]             m_r_data,
    output logic [NUM_MASTERS-1:0]        m_r_valid,
    input  logic [NUM_MASTERS-1:0]        m_r_ready,
    output logic [ADDR_W-1:0]             s_ar_addr,
    output logic                          s_ar_valid,
    input  logic                          s_ar_ready,
    input  logic [DATA_W-1:0]             s_r_data,
    input  logic                          s_r_valid,
    output logic                          s_r_ready,
    output logic [NUM_MASTERS-1:0]        gnt
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'h0};

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         gnt_idx;
    logic [ADDR_W-1:0]        addr_q;
    logic                     any_req;
    logic [IDX_W-1:0]         win_idx;
    logic [ADDR_W-1:0]        win_addr;
    logic [NUM_MASTERS-1:0]   gnt_oh;
    logic                     r_done;

    assign any_req = |m_ar_valid;

`ifdef REFILL_ARB_RR_EN
    logic [IDX_W-1:0] last_grant;
    int               dist;
    int               best;

    // Winner is the requester closest after last_grant in circular order.
    always_comb begin
        win_idx = '0;
        best    = NUM_MASTERS;
        dist    = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            dist = (i + NUM_MASTERS - 1 - int'(last_grant)) % NUM_MASTERS;
            if (m_ar_valid[i] && dist < best) begin
                best    = dist;
                win_idx = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_ar_valid[i]) win_idx = IDX_W'(i);
        end
    end
`endif

    always_comb begin
        win_addr = '0;
        gnt_oh   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_idx == IDX_W'(i)) win_addr = m_ar_addr[i*ADDR_W +: ADDR_W];
            gnt_oh[i] = (gnt_idx == IDX_W'(i));
        end
    end

    assign r_done = (state == DATA) && s_r_valid && s_r_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            gnt_idx <= '0;
`ifdef REFILL_ARB_RR_EN
            last_grant <= IDX_W'(NUM_MASTERS - 1);
`endif
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt_idx <= win_idx;
                    state   <= ADDR;
                end
                ADDR: if (s_ar_ready) state <= DATA;
                DATA: if (r_done) begin
                    state <= IDLE;
`ifdef REFILL_ARB_RR_EN
                    last_grant <= gnt_idx;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address is captured at grant so the bus request stays stable even if the requester drops.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) addr_q <= win_addr & LINE_MASK;
    end

    always_comb begin
        gnt        = (state != IDLE) ? gnt_oh : '0;
        s_ar_valid = (state == ADDR);
        s_ar_addr  = (state == ADDR) ? addr_q : '0;
        m_ar_ready = (state == ADDR && s_ar_ready) ? gnt_oh : '0;
        s_r_ready  = (state == DATA) && |(m_r_ready & gnt_oh);
        m_r_valid  = (state == DATA && s_r_valid) ? gnt_oh : '0;
        m_r_data   = (state == DATA) ? s_r_data : '0;
    end
endmodule

// File: tb/tb_refill_read_arbiter.sv
// Self-checking bench for refill_read_arbiter: directed vector table, corner-case sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_refill_read_arbiter;
    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM*AW-1:0]  m_ar_addr;
    logic [NM-1:0]     m_ar_valid;
    logic [NM-1:0]     m_ar_ready;
    logic [DW-1:0]     m_r_data;
    logic [NM-1:0]     m_r_valid;
    logic [NM-1:0]     m_r_ready;
    logic [AW-1:0]     s_ar_addr;
    logic              s_ar_valid;
    logic              s_ar_ready;
    logic [DW-1:0]     s_r_data;
    logic              s_r_valid;
    logic              s_r_ready;
    logic [NM-1:0]     gnt;

    int errors = 0;
    int checks = 0;

    refill_read_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(m_r_data), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_r_data(s_r_data), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        sar;
        logic        srv;
        logic [1:0]  mrr;
        logic [7:0]  db;
        logic [1:0]  e_gnt;
        logic        e_sav;
        logic [31:0] e_addr;
        logic [1:0]  e_mar;
        logic [1:0]  e_mrv;
        logic        e_srr;
    } vec_t;

    vec_t tbl[12];

    // Reference model: which transaction phase is open, who owns it, and the line address.
    int          mdl_phase;
    int          mdl_owner;
    logic [31:0] mdl_addr;
    logic [NM-1:0] exp_mar;
`ifdef REFILL_ARB_RR_EN
    int          mdl_last;
`endif

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic [31:0] a0,
                         input logic [31:0] a1, input logic sar, input logic srv,
                         input logic [1:0] mrr, input logic [7:0] db);
        rst        = r;
        m_ar_valid = v;
        m_ar_addr  = {a1, a0};
        s_ar_ready = sar;
        s_r_valid  = srv;
        m_r_ready  = mrr;
        s_r_data   = {16{db}};
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 8'h00);
        next_cycle();
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_sav", s_ar_valid, 0);
        chk("rst_addr", s_ar_addr, 0);
        chk("rst_mar", m_ar_ready, 0);
        chk("rst_mrv", m_r_valid, 0);
        chk("rst_srr", s_r_ready, 0);
        chk("rst_rdata", m_r_data, 0);
        next_cycle();
        rst = 1'b1;
        mdl_phase = 0;
        mdl_owner = 0;
`ifdef REFILL_ARB_RR_EN
        mdl_last = NM - 1;
`endif
    endtask

    function automatic int pick(input logic [NM-1:0] v);
`ifdef REFILL_ARB_RR_EN
        for (int k = 1; k <= NM; k++) if (v[(mdl_last + k) % NM]) return (mdl_last + k) % NM;
`else
        for (int i = 0; i < NM; i++) if (v[i]) return i;
`endif
        return 0;
    endfunction

    task automatic model_check();
        logic [NM-1:0] e_gnt, e_mar, e_mrv;
        logic          e_sav, e_srr;
        logic [AW-1:0] e_addr;
        e_gnt = '0; e_mar = '0; e_mrv = '0; e_sav = 1'b0; e_srr = 1'b0; e_addr = '0;
        if (mdl_phase != 0) e_gnt[mdl_owner] = 1'b1;
        if (mdl_phase == 1) begin
            e_sav = 1'b1;
            e_addr = mdl_addr;
            e_mar[mdl_owner] = s_ar_ready;
        end
        if (mdl_phase == 2) begin
            e_srr = m_r_ready[mdl_owner];
            e_mrv[mdl_owner] = s_r_valid;
            chk("rnd_rdata", m_r_data, s_r_data);
        end
        exp_mar = e_mar;
        chk("rnd_gnt", gnt, e_gnt);
        chk("rnd_sav", s_ar_valid, e_sav);
        chk("rnd_addr", s_ar_addr, e_addr);
        chk("rnd_mar", m_ar_ready, e_mar);
        chk("rnd_mrv", m_r_valid, e_mrv);
        chk("rnd_srr", s_r_ready, e_srr);
    endtask

    task automatic model_edge();
        if (!rst) begin
            mdl_phase = 0;
`ifdef REFILL_ARB_RR_EN
            mdl_last = NM - 1;
`endif
        end else if (mdl_phase == 0) begin
            if (m_ar_valid != 0) begin
                mdl_owner = pick(m_ar_valid);
                mdl_addr  = m_ar_addr[mdl_owner*AW +: AW] & 32'hFFFF_FFF0;
                mdl_phase = 1;
            end
        end else if (mdl_phase == 1) begin
            if (s_ar_ready) mdl_phase = 2;
        end else if (s_r_valid && m_r_ready[mdl_owner]) begin
            mdl_phase = 0;
`ifdef REFILL_ARB_RR_EN
            mdl_last = mdl_owner;
`endif
        end
    endtask

    initial begin
        logic [NM-1:0] pend;
        logic [31:0]   paddr [NM];
        logic [1:0]    e_seq;

        tbl[0]  = '{1'b1, 2'b01, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 2'b01, 8'h00, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 2'b01, 8'h00, 2'b01, 1'b1, 32'h0000_1230, 2'b01, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 2'b01, 8'hA5, 2'b01, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1};
        tbl[3]  = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b01, 8'h00, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
        tbl[4]  = '{1'b1, 2'b11, 32'h2000_0011, 32'h3000_00FF, 1'b0, 1'b0, 2'b11, 8'h00, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
        tbl[5]  = '{1'b1, 2'b11, 32'h2000_0011, 32'h3000_00FF, 1'b1, 1'b0, 2'b11, 8'h00, 2'b01, 1'b1, 32'h2000_0010, 2'b01, 2'b00, 1'b0};
        tbl[6]  = '{1'b1, 2'b10, 32'h2000_0011, 32'h3000_00FF, 1'b0, 1'b1, 2'b11, 8'h11, 2'b01, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1};
        tbl[7]  = '{1'b1, 2'b10, 32'h2000_0011, 32'h3000_00FF, 1'b0, 1'b0, 2'b11, 8'h00, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
        tbl[8]  = '{1'b1, 2'b10, 32'h2000_0011, 32'h3000_00FF, 1'b1, 1'b0, 2'b11, 8'h00, 2'b10, 1'b1, 32'h3000_00F0, 2'b10, 2'b00, 1'b0};
        tbl[9]  = '{1'b1, 2'b00, 32'h2000_0011, 32'h3000_00FF, 1'b0, 1'b1, 2'b11, 8'h3C, 2'b10, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1};
        tbl[10] = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 8'h77, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
        tbl[11] = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 8'h77, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].a0, tbl[i].a1, tbl[i].sar, tbl[i].srv, tbl[i].mrr, tbl[i].db);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].e_gnt);
            chk($sformatf("vec%0d_sav", i), s_ar_valid, tbl[i].e_sav);
            chk($sformatf("vec%0d_addr", i), s_ar_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_mar", i), m_ar_ready, tbl[i].e_mar);
            chk($sformatf("vec%0d_mrv", i), m_r_valid, tbl[i].e_mrv);
            chk($sformatf("vec%0d_srr", i), s_r_ready, tbl[i].e_srr);
            if (tbl[i].e_mrv != 0) chk($sformatf("vec%0d_rdata", i), m_r_data, {16{tbl[i].db}});
            next_cycle();
        end

        // Both masters request continuously: grant order depends on the arbitration mode.
        do_reset();
        drive(1'b1, 2'b11, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b1, 2'b11, 8'h5A);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 3 == 1) begin
`ifdef REFILL_ARB_RR_EN
                e_seq = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
`else
                e_seq = 2'b01;
`endif
                chk($sformatf("seq_gnt%0d", c / 3), gnt, e_seq);
            end else if (c % 3 == 0) begin
                chk($sformatf("seq_bubble%0d", c / 3), gnt, 0);
            end
            next_cycle();
        end

        // Address and data backpressure.
        do_reset();
        drive(1'b1, 2'b01, 32'h0000_ABCD, 32'h0, 1'b0, 1'b0, 2'b01, 8'h00);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_sav", s_ar_valid, 1);
            chk("bp_addr", s_ar_addr, 32'h0000_ABC0);
            chk("bp_mar", m_ar_ready, 0);
            chk("bp_gnt", gnt, 2'b01);
            next_cycle();
        end
        s_ar_ready = 1'b1;
        @(negedge clk);
        chk("bp_mar_acc", m_ar_ready, 2'b01);
        next_cycle();
        drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 8'hC3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_srr_hold", s_r_ready, 0);
            chk("bp_mrv_hold", m_r_valid, 2'b01);
            chk("bp_gnt_hold", gnt, 2'b01);
            next_cycle();
        end
        m_r_ready = 2'b01;
        @(negedge clk);
        chk("bp_srr_go", s_r_ready, 1);
        chk("bp_rdata", m_r_data, {16{8'hC3}});
        next_cycle();
        @(negedge clk);
        chk("bp_idle_gnt", gnt, 0);
        next_cycle();

        // Reset during DATA abandons the transaction; m1 alone is then served.
        do_reset();
        drive(1'b1, 2'b01, 32'h0000_4444, 32'h0000_5555, 1'b1, 1'b0, 2'b01, 8'h00);
        next_cycle();
        next_cycle();
        drive(1'b0, 2'b00, 32'h0000_4444, 32'h0000_5555, 1'b0, 1'b1, 2'b01, 8'hEE);
        @(negedge clk);
        chk("rstd_in_data", gnt, 2'b01);
        next_cycle();
        drive(1'b1, 2'b10, 32'h0000_4444, 32'h0000_5555, 1'b1, 1'b1, 2'b11, 8'hEE);
        @(negedge clk);
        chk("rstd_gnt", gnt, 0);
        chk("rstd_srr", s_r_ready, 0);
        chk("rstd_mrv", m_r_valid, 0);
        chk("rstd_sav", s_ar_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("rstd_m1_gnt", gnt, 2'b10);
        chk("rstd_m1_addr", s_ar_addr, 32'h0000_5550);
        next_cycle();

        // Randomized traffic against the reference model; masters hold requests until accepted.
        do_reset();
        pend = '0;
        for (int i = 0; i < NM; i++) paddr[i] = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    paddr[i] = $urandom;
                end
            end
            rst        = ($urandom_range(0, 99) != 0);
            m_ar_valid = pend;
            m_ar_addr  = {paddr[1], paddr[0]};
            s_ar_ready = ($urandom_range(0, 2) != 0);
            s_r_valid  = 1'($urandom_range(0, 1));
            m_r_ready  = 2'($urandom_range(0, 3));
            s_r_data   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            model_check();
            pend = pend & ~exp_mar;
            model_edge();
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
